// File: rtl/press_pkg.sv
// Shared definitions for the press conditioner: FSM state encoding and
// default timing constants.
package press_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    PRESSED     = 3'd2,
    REPEAT      = 3'd3,
    DEB_RELEASE = 3'd4
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES     = 16;
  localparam int DEF_REPEAT_CYCLES   = 8;
  localparam bit DEF_REPEAT_EN       = 1'b1;
  localparam int DEF_CNT_W           = 8;
  localparam int PRESS_COUNT_W       = 8;

endpackage

// File: rtl/press_conditioner_cycle_counter.sv
// Shared cycle counter for the press conditioner FSM; flags when the count
// equals the terminal value selected by the current state.
module cycle_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load_one,
  input  logic         inc,
  input  logic [W-1:0] terminal,
  output logic         tc
);

  logic [W-1:0] cnt;

  // clear wins over load_one, which wins over inc
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load_one) begin
      cnt <= W'(1);
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == terminal);

endmodule

// File: rtl/press_conditioner.sv
// Button debouncer with press/release strobes, optional auto-repeat and a
// wrapping press counter. The current FSM state is exposed on `state`.
module press_conditioner
  import press_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit REPEAT_EN       = DEF_REPEAT_EN,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     metaFree,
  output logic                     level,
  output logic                     pulse,
  output logic                     rel_pulse,
  output logic [PRESS_COUNT_W-1:0] press_count,
  output logic [2:0]               state
);

  localparam logic [CNT_W-1:0] DEB_T  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_T = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_T  = CNT_W'(REPEAT_CYCLES - 1);

  state_t                   state_q, state_n;
  logic                     level_n, pulse_n, rel_n;
  logic [PRESS_COUNT_W-1:0] count_n;
  logic                     clr, ld, inc, tc;
  logic [CNT_W-1:0]         terminal;

  cycle_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (clr),
    .load_one (ld),
    .inc      (inc),
    .terminal (terminal),
    .tc       (tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      level       <= 1'b0;
      pulse       <= 1'b0;
      rel_pulse   <= 1'b0;
      press_count <= '0;
    end else begin
      state_q     <= state_n;
      level       <= level_n;
      pulse       <= pulse_n;
      rel_pulse   <= rel_n;
      press_count <= count_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    level_n  = level;
    pulse_n  = 1'b0;
    rel_n    = 1'b0;
    count_n  = press_count;
    clr      = 1'b0;
    ld       = 1'b0;
    inc      = 1'b0;
    terminal = DEB_T;
    case (state_q)
      IDLE: begin
        if (metaFree) begin
          state_n = DEB_PRESS;
          ld      = 1'b1;
        end
      end
      DEB_PRESS: begin
        if (!metaFree) begin
          state_n = IDLE;
          clr     = 1'b1;
        end else if (tc) begin
          state_n = PRESSED;
          level_n = 1'b1;
          pulse_n = 1'b1;
          count_n = press_count + 1'b1;
          clr     = 1'b1;
        end else begin
          inc = 1'b1;
        end
      end
      PRESSED: begin
        terminal = HOLD_T;
        if (!metaFree) begin
          state_n = DEB_RELEASE;
          ld      = 1'b1;
        end else if (tc) begin
          // Without auto-repeat the hold timer simply parks at its terminal
          if (REPEAT_EN) begin
            state_n = REPEAT;
            pulse_n = 1'b1;
            count_n = press_count + 1'b1;
            clr     = 1'b1;
          end
        end else begin
          inc = 1'b1;
        end
      end
      REPEAT: begin
        terminal = REP_T;
        if (!metaFree) begin
          state_n = DEB_RELEASE;
          ld      = 1'b1;
        end else if (tc) begin
          pulse_n = 1'b1;
          count_n = press_count + 1'b1;
          clr     = 1'b1;
        end else begin
          inc = 1'b1;
        end
      end
      DEB_RELEASE: begin
        if (metaFree) begin
          // Bounce: stay pressed and restart the hold timer
          state_n = PRESSED;
          clr     = 1'b1;
        end else if (tc) begin
          state_n = IDLE;
          level_n = 1'b0;
          rel_n   = 1'b1;
          clr     = 1'b1;
        end else begin
          inc = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        level_n = 1'b0;
        count_n = '0;
        clr     = 1'b1;
      end
    endcase
  end

  assign state = state_q;

endmodule
